spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
- Serial front end feeding the single-port RAM.
- Deserialises MOSI frames from an SPI master into 10-bit RAM command words on rx_data/rx_valid.
- In the read-data phase, captures the RAM's tx_data/tx_valid response and serialises it back on MISO.
- Everything runs on the system clock: SPI pins are sampled, no SCK domain.

Parameters:
- FRAME_W, 10, bits per RAM command word (2 opcode bits and 8 payload bits).
- DATA_W, 8, width of RAM read data shifted out on MISO.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- SS_n  input  1  slave select, active low.
- MOSI  input  1  serial data from master, MSB first.
- MISO  output  1  serial read data to master, MSB first.
- rx_data  output  FRAME_W  assembled command word to RAM (din).
- rx_valid  output  1  one-cycle strobe: rx_data valid.
- tx_data  input  DATA_W  RAM read data (dout).
- tx_valid  input  1  RAM read data valid.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rx_data=0, rx_valid=0, MISO=0.
  - Bit counter=0, rd_addr_seen flag=0.
  - rst overrides SS_n, MOSI and tx_valid in that cycle.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE:
  - SS_n sampled 0 -> CHK_CMD; otherwise stay.
- CHK_CMD:
  - Samples one command bit on MOSI; this bit is not stored.
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA, receive:
  - Shift MOSI in MSB first, one bit per clk, for FRAME_W cycles.
  - The cycle after the FRAME_W-th bit:
    - rx_data = assembled word.
    - rx_valid=1 for exactly one cycle.
  - rx_data holds its value until the next frame completes.
  - Opcode bits are not checked: rx_data[9:8] is forwarded as received.
- READ_ADD completion: set rd_addr_seen=1 in the same cycle as rx_valid.
- READ_DATA:
  - Set rd_addr_seen=0 in the same cycle as rx_valid.
  - Then wait for tx_valid=1.
  - tx_valid sampled high -> latch tx_data.
  - MISO drives tx_data[7], [6], ... [0] on the following DATA_W cycles, one bit per clk.
  - After the last bit, MISO returns to 0.
  - tx_valid outside the wait window is ignored.
  - A second tx_valid during shift-out is ignored.
- After a frame completes, stay in the current state with counters idle until SS_n=1.
  - Extra MOSI bits are ignored.
  - No rx_valid is re-issued.
- SS_n sampled 1 in any non-IDLE state:
  - Next state is IDLE.
  - Bit counter clears and any partial frame is discarded, with no rx_valid.
  - MISO is forced to 0 and an in-progress shift-out is aborted.
  - rd_addr_seen is retained.
- SS_n=1 in the same cycle as the FRAME_W-th bit: the frame is discarded, with no rx_valid. SS_n takes priority.
- MISO=0 whenever not shifting read data.
- rx_valid never asserts in IDLE or CHK_CMD.
- Bit counter: counts 0..FRAME_W-1, then DATA_W-1..0 for transmit. No wrap-around; it holds when done.

Test Plan:
- Reset: rst=1 for 2 cycles with SS_n=0 and MOSI toggling -> rx_valid=0, MISO=0, rx_data=0, state IDLE.
- Write address:
  - Stimulus: SS_n low, MOSI = 0 then 10'b00_1010_0101.
  - Required: rx_data=0x0A5 with a single rx_valid pulse on the cycle after bit 10; no MISO activity.
- Write data: SS_n low, MOSI = 0 then 10'b01_0011_1100 -> rx_data=0x13C, one rx_valid pulse.
- Read sequence:
  - Stimulus: cmd 1 + 10'b10_1010_0101 (READ_ADD); deassert SS_n; cmd 1 + 10'b11_0000_0000 (READ_DATA); RAM returns tx_data=0xC3 with tx_valid.
  - Required: rx_data=0x2A5 then 0x300; MISO emits 1,1,0,0,0,0,1,1 on the 8 cycles after tx_valid; rd_addr_seen ends at 0.
- Abort:
  - Stimulus: SS_n rises after 6 of 10 WRITE bits.
  - Required: no rx_valid; next frame 0 + 10'b00_0000_0001 yields rx_data=0x001.
- Abort mid-transmit: SS_n rises after 3 MISO bits -> MISO=0 next cycle, IDLE, following read frame goes to READ_ADD.

Source files
------------

// File: rtl/spi_slave_if_if.sv
// Purpose: bundles the SPI pins and the RAM command/response bus of the SPI slave front end.
// Latency: none, wires only.
// Backpressure: none; rx_valid and tx_valid are single-cycle strobes with no ready.
// Ports: SS_n/MOSI/MISO are SPI pins; rx_data/rx_valid carry commands to the RAM;
//        tx_data/tx_valid return RAM read data. The master modport is the SPI master plus RAM side,
//        and the slave modport is the front end itself.
interface spi_slave_if_if #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
) ();
    logic               SS_n;
    logic               MOSI;
    logic               MISO;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic [DATA_W-1:0]  tx_data;
    logic               tx_valid;

    modport master (
        output SS_n, MOSI, tx_data, tx_valid,
        input  MISO, rx_data, rx_valid
    );

    modport slave (
        input  SS_n, MOSI, tx_data, tx_valid,
        output MISO, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_if.sv
// Purpose: SPI slave on the system clock. It deserialises MOSI frames into RAM command words and
//          serialises RAM read data back out on MISO.
// Latency: rx_valid is asserted in the cycle after the last frame bit is sampled. MISO carries the
//          read-data MSB in the cycle after tx_valid is sampled.
// Backpressure: none. The SPI master paces the traffic, and SS_n high aborts any frame or shift-out
//               in progress.
// Ports: clk and rst (synchronous, active high) are plain ports; everything else is carried by
//        bus (spi_slave_if_if.slave).
module spi_slave_if #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    spi_slave_if_if.slave bus
);
    localparam int CNT_W = $clog2((FRAME_W > DATA_W) ? FRAME_W : DATA_W);
    localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] TX_FIRST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHK_CMD   = 3'd1;
    localparam logic [2:0] WRITE     = 3'd2;
    localparam logic [2:0] READ_ADD  = 3'd3;
    localparam logic [2:0] READ_DATA = 3'd4;

    logic [2:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic               rd_addr_seen;
    logic [FRAME_W-2:0] rx_shift;
    logic [FRAME_W-1:0] rx_word;
    logic               rx_strobe;
    logic               rx_done;     // frame complete, counters parked until SS_n rises
    logic [DATA_W-1:0]  tx_buf;      // remaining read bits, next one at the MSB
    logic               tx_active;   // MISO is currently carrying read data
    logic               tx_done;     // read data already sent; any later tx_valid is ignored
    logic               miso_bit;

    assign bus.rx_data  = rx_word;
    assign bus.rx_valid = rx_strobe;
    assign bus.MISO     = miso_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rd_addr_seen <= 1'b0;
            rx_shift     <= '0;
            rx_word      <= '0;
            rx_strobe    <= 1'b0;
            rx_done      <= 1'b0;
            tx_buf       <= '0;
            tx_active    <= 1'b0;
            tx_done      <= 1'b0;
            miso_bit     <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            if (state != IDLE && bus.SS_n) begin
                // Deselect wins over everything. The partial frame is dropped and the shift-out
                // is cut short, but rd_addr_seen is kept.
                state     <= IDLE;
                cnt       <= '0;
                rx_done   <= 1'b0;
                tx_active <= 1'b0;
                tx_done   <= 1'b0;
                miso_bit  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!bus.SS_n) begin
                            state <= CHK_CMD;
                        end
                    end
                    CHK_CMD: begin
                        cnt       <= '0;
                        rx_done   <= 1'b0;
                        tx_active <= 1'b0;
                        tx_done   <= 1'b0;
                        if (!bus.MOSI) begin
                            state <= WRITE;
                        end else if (rd_addr_seen) begin
                            state <= READ_DATA;
                        end else begin
                            state <= READ_ADD;
                        end
                    end
                    WRITE, READ_ADD, READ_DATA: begin
                        if (!rx_done) begin
                            if (cnt == RX_LAST) begin
                                rx_word   <= {rx_shift, bus.MOSI};
                                rx_strobe <= 1'b1;
                                rx_done   <= 1'b1;
                                if (state == READ_ADD) begin
                                    rd_addr_seen <= 1'b1;
                                end else if (state == READ_DATA) begin
                                    rd_addr_seen <= 1'b0;
                                end
                            end else begin
                                rx_shift <= {rx_shift[FRAME_W-3:0], bus.MOSI};
                                cnt      <= cnt + 1'b1;
                            end
                        end else if (state == READ_DATA && !tx_done) begin
                            if (!tx_active) begin
                                // Wait window: the first tx_valid after the frame starts the shift-out.
                                if (bus.tx_valid) begin
                                    tx_active <= 1'b1;
                                    miso_bit  <= bus.tx_data[DATA_W-1];
                                    tx_buf    <= bus.tx_data << 1;
                                    cnt       <= TX_FIRST;
                                end
                            end else if (cnt == '0) begin
                                tx_active <= 1'b0;
                                tx_done   <= 1'b1;
                                miso_bit  <= 1'b0;
                            end else begin
                                miso_bit <= tx_buf[DATA_W-1];
                                tx_buf   <= tx_buf << 1;
                                cnt      <= cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// Purpose: checks spi_slave_if against a frame-level model with randomized traffic.
// Latency: the model expects rx_valid one cycle after the last bit and MISO one cycle after tx_valid.
// Backpressure: not applicable. A driver pushes expectations and a monitor compares them at negedge.
module tb_spi_slave_if;
    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    typedef struct {
        logic [FRAME_W-1:0] word;
        int                 at;
    } rx_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    bit   rd_seen = 1'b0;            // model of the read-address-received flag
    rx_exp_t            exp_rx[$];
    bit                 exp_miso[int];   // expected MISO keyed by cycle; absent means 0
    logic [FRAME_W-1:0] last_rx = '0;
    rx_exp_t            e;
    bit                 em;

    spi_slave_if_if #(.FRAME_W(FRAME_W), .DATA_W(DATA_W)) bus ();

    spi_slave_if #(.FRAME_W(FRAME_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, req);
        end
    endtask

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] rbyte();
        return 8'($urandom);
    endfunction

    // Monitor: compares every cycle against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            em = exp_miso.exists(cyc) ? exp_miso[cyc] : 1'b0;
            check("miso", 32'(bus.MISO), 32'(em));
            if (bus.rx_valid === 1'b1) begin
                if (exp_rx.size() == 0) begin
                    check("rx_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_rx.pop_front();
                    check("rx_cycle", cyc, e.at);
                    check("rx_data", 32'(bus.rx_data), 32'(e.word));
                    last_rx = e.word;
                end
            end else begin
                check("rx_valid_low", 32'(bus.rx_valid), 32'd0);
                check("rx_hold", 32'(bus.rx_data), 32'(last_rx));
            end
        end
    end

    // Drives one cycle of inputs, sampled at the next rising edge.
    task automatic step(input bit ss, input bit mosi, input bit tv, input logic [7:0] td);
        bus.SS_n     = ss;
        bus.MOSI     = mosi;
        bus.tx_valid = tv;
        bus.tx_data  = td;
        @(posedge clk);
        #1;
    endtask

    task automatic deselect();
        repeat ($urandom_range(1, 3)) step(1'b1, rbit(), rbit(), rbyte());
    endtask

    // One SPI transaction. abort_at < FRAME_W raises SS_n instead of sending that data bit.
    // tx_abort in 1..DATA_W raises SS_n after that many MISO bits (0 means no abort).
    task automatic run_frame(input bit cmd, input logic [FRAME_W-1:0] word, input int abort_at,
                             input bit offer_tx, input logic [7:0] txd, input int tx_wait,
                             input int tx_abort);
        bit      is_rd_data;
        int      n;
        rx_exp_t x;
        is_rd_data = cmd && rd_seen;
        step(1'b0, rbit(), rbit(), rbyte());
        step(1'b0, cmd, rbit(), rbyte());
        for (int i = 0; i < FRAME_W; i++) begin
            if (i == abort_at) begin
                step(1'b1, word[FRAME_W-1-i], 1'b0, 8'h00);
                deselect();
                return;
            end
            if (i == FRAME_W - 1) begin
                x.word = word;
                x.at   = cyc + 1;
                exp_rx.push_back(x);
            end
            step(1'b0, word[FRAME_W-1-i], (i < FRAME_W - 1) ? rbit() : 1'b0, rbyte());
        end
        if (cmd) rd_seen = !rd_seen;
        for (int w = 0; w < tx_wait; w++) step(1'b0, rbit(), is_rd_data ? 1'b0 : rbit(), rbyte());
        if (offer_tx) begin
            n = cyc;
            if (is_rd_data) begin
                for (int i = 0; i < DATA_W; i++) exp_miso[n + 1 + i] = txd[DATA_W-1-i];
            end
            step(1'b0, rbit(), 1'b1, txd);
            for (int j = 1; j <= DATA_W + 1; j++) begin
                if (j == tx_abort) begin
                    for (int k = n + j + 1; k <= n + DATA_W + 1; k++) begin
                        if (exp_miso.exists(k)) exp_miso.delete(k);
                    end
                    break;
                end
                step(1'b0, rbit(), rbit(), rbyte());
            end
        end
        deselect();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.SS_n     = 1'b0;
        bus.MOSI     = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        repeat (2) begin
            @(posedge clk);
            #1;
            bus.MOSI = ~bus.MOSI;
        end
        @(negedge clk);
        check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_miso", 32'(bus.MISO), 32'd0);
        check("reset_rx_data", 32'(bus.rx_data), 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.SS_n     = 1'b1;
        bus.tx_valid = 1'b0;
        mon_en       = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Write address and write data.
        run_frame(1'b0, 10'h0A5, FRAME_W, 1'b1, rbyte(), 1, 0);
        run_frame(1'b0, 10'h13C, FRAME_W, 1'b0, 8'h00, 0, 0);
        // Read address, then read data, with the RAM returning 0xC3.
        run_frame(1'b1, 10'h2A5, FRAME_W, 1'b1, 8'h5A, 1, 0);
        run_frame(1'b1, 10'h300, FRAME_W, 1'b1, 8'hC3, 2, 0);
        // Abort after 6 write bits, then a clean frame.
        run_frame(1'b0, 10'h3FF, 6, 1'b0, 8'h00, 0, 0);
        run_frame(1'b0, 10'h001, FRAME_W, 1'b0, 8'h00, 0, 0);
        // Deselect in the same cycle as the last bit drops the frame.
        run_frame(1'b0, 10'h155, FRAME_W - 1, 1'b0, 8'h00, 0, 0);
        // Abort the shift-out after 3 bits; the next read frame must be treated as an address.
        run_frame(1'b1, 10'h2F0, FRAME_W, 1'b1, rbyte(), 0, 0);
        run_frame(1'b1, 10'h3AA, FRAME_W, 1'b1, 8'hB6, 0, 3);
        run_frame(1'b1, 10'h211, FRAME_W, 1'b1, 8'hE7, 1, 0);
        run_frame(1'b1, 10'h322, FRAME_W, 1'b1, 8'h81, 3, 0);

        for (int t = 0; t < 80; t++) begin
            run_frame(rbit(), 10'($urandom),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FRAME_W - 1)) : FRAME_W,
                      ($urandom_range(0, 5) != 0), rbyte(), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DATA_W)) : 0);
        end

        repeat (4) step(1'b1, 1'b0, 1'b0, 8'h00);
        check("rx_pending", 32'(exp_rx.size()), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
